// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_W = 32;

    localparam logic [7:0]  DEF_PAT = 8'b0010_1010;
    localparam int unsigned DEF_LEN = 6;
    localparam bit          DEF_OVL = 1'b1;

    // Mask with the low len bits set; callers truncate to their own pattern width.
    function automatic logic [MAX_PAT_W-1:0] len_mask(input int unsigned len);
        logic [MAX_PAT_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; clear takes priority over increment.
module seq_match_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered match pulse and saturating match count.
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 8,
    parameter int unsigned      LEN_W   = $clog2(PAT_W + 1),
    parameter int unsigned      CNT_W   = 16,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
    parameter int unsigned      DEF_LEN = seq_det_pkg::DEF_LEN,
    parameter bit               DEF_OVL = seq_det_pkg::DEF_OVL
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    import seq_det_pkg::*;

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [PAT_W-2:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    logic [PAT_W-1:0] hist_next_c;
    logic [LEN_W-1:0] fill_inc_c;
    logic [PAT_W-1:0] mask_c;
    logic             match_c;

    // Candidate history/fill if a bit is accepted, and the masked compare.
    always_comb begin
        hist_next_c = {hist_q, x};
        fill_inc_c  = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
        mask_c      = PAT_W'(len_mask(32'(len_q)));
        match_c     = x_valid && !cfg_load && !cfg_err
                      && (fill_inc_c >= len_q)
                      && ((hist_next_c & mask_c) == (pattern_q & mask_c));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pattern_q <= DEF_PAT;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVL;
            cfg_err   <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            z         <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            cfg_err   <= (cfg_len == '0) || (cfg_len > FILL_MAX);
            hist_q    <= '0;
            fill_q    <= '0;
            z         <= 1'b0;
        end else begin
            z <= match_c;
            if (x_valid) begin
                hist_q <= hist_next_c[PAT_W-2:0];
                // Non-overlapping mode demands len fresh bits after each match.
                fill_q <= (match_c && !overlap_q) ? '0 : fill_inc_c;
            end
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (match_c),
        .clr     (cnt_clr),
        .count   (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed table, corner sequences and random
// stimulus against a queue-based reference model.
module tb_seq_detector_param;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;

    logic             clock = 1'b0;
    logic             reset_n, x, x_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             z, cfg_err, z_s, cfg_err_s;
    logic [15:0]      match_count;
    logic [1:0]       match_count_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .z(z), .match_count(match_count), .cfg_err(cfg_err));

    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .z(z_s), .match_count(match_count_s), .cfg_err(cfg_err_s));

    // Reference model: accepted bits since the last history clear, newest last.
    bit         q[$];
    bit [7:0]   m_pat;
    int         m_len;
    bit         m_ovl, m_err, m_z;
    longint     m_cnt;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit m;
        if (!reset_n) begin
            m_pat = 8'b0010_1010; m_len = 6; m_ovl = 1'b1; m_err = 1'b0;
            q.delete(); m_z = 1'b0; m_cnt = 0;
        end else if (cfg_load) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            m_err = (m_len == 0) || (m_len > PAT_W);
            q.delete(); m_z = 1'b0;
            if (cnt_clr) m_cnt = 0;
        end else begin
            m = 1'b0;
            if (x_valid) begin
                q.push_back(x);
                if (q.size() > PAT_W) void'(q.pop_front());
                if (!m_err && q.size() >= m_len) begin
                    m = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (q[q.size() - 1 - i] != m_pat[i]) m = 1'b0;
                end
                if (m && !m_ovl) q.delete();
            end
            m_z = m;
            if (cnt_clr) m_cnt = 0;
            else if (m) m_cnt++;
        end
    endtask

    task automatic step(input bit rn, input bit xv, input bit xb, input bit cl,
                        input logic [7:0] cp, input logic [3:0] clen, input bit co,
                        input bit cc);
        reset_n = rn; x_valid = xv; x = xb; cfg_load = cl;
        cfg_pattern = cp; cfg_len = clen; cfg_overlap = co; cnt_clr = cc;
        model_update();
        @(posedge clock); #1;
        check("z", z, m_z);
        check("count", match_count, sat(m_cnt, 65535));
        check("cfg_err", cfg_err, m_err);
        check("z_sat", z_s, m_z);
        check("count_sat", match_count_s, sat(m_cnt, 3));
    endtask

    task automatic rst();
        step(0, 0, 0, 0, 8'h0, 4'd0, 0, 0);
    endtask
    task automatic bit_in(input bit b);
        step(1, 1, b, 0, 8'h0, 4'd0, 0, 0);
    endtask
    task automatic idle();
        step(1, 0, 0, 0, 8'h0, 4'd0, 0, 0);
    endtask
    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        step(1, 0, 0, 1, p, l, o, 1);
    endtask

    typedef struct {
        bit     rn;
        bit     xv;
        bit     xb;
        bit     exp_z;
        longint exp_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit [9:0] stream;
        reset_n = 0; x = 0; x_valid = 0; cfg_load = 0; cfg_pattern = '0;
        cfg_len = '0; cfg_overlap = 0; cnt_clr = 0;

        // Default config, overlapping: 1010101010 matches at bits 6, 8, 10.
        vecs.push_back('{0, 0, 0, 0, 0});
        stream = 10'b1010101010;
        for (int i = 0; i < 10; i++) begin
            automatic int b = i + 1;
            automatic bit hit = (b == 6) || (b == 8) || (b == 10);
            automatic longint c = (b >= 10) ? 3 : (b >= 8) ? 2 : (b >= 6) ? 1 : 0;
            vecs.push_back('{1, 1, stream[9 - i], hit, c});
        end
        foreach (vecs[i]) begin
            step(vecs[i].rn, vecs[i].xv, vecs[i].xb, 0, 8'h0, 4'd0, 0, 0);
            check("tbl_z", z, vecs[i].exp_z);
            check("tbl_count", match_count, vecs[i].exp_cnt);
        end
        check("tbl_sat_count", match_count_s, 3);

        // Non-overlapping: only the first 101010 counts.
        load(8'b0010_1010, 4'd6, 0);
        for (int i = 0; i < 10; i++) begin
            bit_in(stream[9 - i]);
            if (i == 5) check("novl_z6", z, 1);
        end
        check("novl_count", match_count, 1);

        // Reconfigure to 111 overlapping; then mid-stream reload discards history.
        load(8'b0000_0111, 4'd3, 1);
        for (int i = 0; i < 5; i++) bit_in(1);
        check("ones_count", match_count, 3);
        bit_in(1);
        load(8'b0000_0111, 4'd3, 1);
        bit_in(1); bit_in(1);
        check("reload_no_z", z, 0);
        bit_in(1);
        check("reload_z", z, 1);

        // Saturation on the 2-bit counter, then clear coinciding with a match.
        load(8'b0000_0111, 4'd3, 1);
        for (int i = 0; i < 7; i++) bit_in(1);
        check("sat_hold", match_count_s, 3);
        check("nosat_count", match_count, 5);
        step(1, 1, 1, 0, 8'h0, 4'd0, 0, 1);
        check("clr_win_z", z, 1);
        check("clr_win_count", match_count, 0);

        // Default pattern with x_valid gaps.
        load(8'b0010_1010, 4'd6, 1);
        for (int i = 0; i < 6; i++) begin
            idle();
            bit_in(stream[9 - i]);
        end
        check("gap_z", z, 1);
        idle();
        check("gap_z_drop", z, 0);

        // Invalid lengths suppress all matches.
        load(8'h00, 4'd0, 1);
        check("len0_err", cfg_err, 1);
        for (int i = 0; i < 12; i++) bit_in(0);
        check("len0_count", match_count, 0);
        load(8'hFF, 4'd9, 1);
        check("len9_err", cfg_err, 1);
        for (int i = 0; i < 12; i++) bit_in(1);
        check("len9_count", match_count, 0);

        // Reset after bit 5 of 101010: no match, defaults restored.
        load(8'b0000_0111, 4'd3, 1);
        for (int i = 0; i < 5; i++) bit_in(stream[9 - i]);
        rst();
        check("rst_err", cfg_err, 0);
        bit_in(0);
        check("rst_no_z", z, 0);
        for (int i = 0; i < 6; i++) bit_in(stream[9 - i]);
        check("rst_default_z", z, 1);

        // Random traffic with occasional reconfiguration, clears and resets.
        for (int i = 0; i < 3000; i++) begin
            automatic int r = $urandom_range(0, 999);
            if (r < 5) rst();
            else if (r < 30)
                load(8'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                                : 4'($urandom_range(1, 4)),
                     1'($urandom));
            else
                step(1, $urandom_range(0, 3) != 0, 1'($urandom), 0, 8'h0, 4'd0, 0,
                     $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the general successor to the fixed 101010 detector. It matches a runtime-programmable bit pattern of 1..PAT_W bits on a qualified serial input stream. Detection is overlapping or non-overlapping, selectable per configuration. The block produces a registered one-cycle match pulse and a saturating match count, and sits on the serial receive path as a framing/marker detector.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2)
- LEN_W, $clog2(PAT_W+1): width of the length field
- CNT_W, 16: match counter width
- DEF_PAT, 8'b0010_1010: pattern value after reset (low DEF_LEN bits used)
- DEF_LEN, 6: pattern length after reset
- DEF_OVL, 1: overlap mode after reset

- clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- x  in  1  serial data bit
- x_valid  in  1  x is sampled only when high
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
- cfg_pattern  in  PAT_W  new pattern; bit [len-1] is first received, bit [0] last received
- cfg_len  in  LEN_W  new pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cnt_clr  in  1  clear match_count
- z  out  1  registered match pulse
- match_count  out  CNT_W  saturating number of matches
- cfg_err  out  1  active configuration invalid (len 0 or > PAT_W)

## Operation
- Reset (reset_n low at an edge): z=0, match_count=0, cfg_err=0, history=0, fill=0, active config = DEF_PAT/DEF_LEN/DEF_OVL.
- Accepted bit (x_valid=1, cfg_load=0): hist_next = {hist[PAT_W-2:0], x}. fill_next = min(fill+1, PAT_W).
- Match condition: cfg_err=0, fill_next ≥ len, and hist_next[len-1:0] == pattern[len-1:0]. Compare with a mask and no variable part-selects.
- On a match: z=1 next cycle and match_count increments. match_count holds at 2^CNT_W-1 and does not wrap.
- Overlap=1: history and fill are kept, so the suffix of a match can start the next one.
- Overlap=0: fill is forced to 0 on a match, so the next match needs len fresh bits.
- No accepted bit: z=0 next cycle, history and fill unchanged.
- cfg_load=1 latches the new config. Same edge: history=0, fill=0, z=0. Any x_valid bit in that cycle is discarded. cfg_err = (cfg_len==0 || cfg_len>PAT_W).
- While cfg_err=1, no matches occur. Bits are still shifted in.
- cnt_clr=1 sets match_count=0. If a match occurs in the same cycle, cnt_clr wins and the count becomes 0 (the match is not counted). z still pulses.
- reset_n low overrides cfg_load, cnt_clr and x_valid.

## Timing
- Latency is 1 cycle: the bit completing a pattern is sampled at edge N, and z is high from N until N+1.
- z is high for exactly one cycle per match. Back-to-back matches on consecutive accepted bits give consecutive z highs (overlap=1, periodic patterns).
- match_count updates on the same edge z rises.
- x_valid gaps do not disturb matching. Only accepted bits count toward pattern position.
- New config is effective for the first accepted bit after the cfg_load edge.

## Structure
- Package seq_det_pkg holds the DEF_* constants and a function len_mask(len) returning a PAT_W-bit mask of the low len bits.
- Sub-module seq_match_counter is a CNT_W saturating counter with clear-priority inc/clr.
- The top module holds the history shift register, fill counter, config registers, comparator and z register.

## Test plan
- Defaults, overlap: after reset feed 1,0,1,0,1,0,1,0,1,0 with x_valid=1 every cycle -> z pulses after bits 6, 8 and 10; match_count=3.
- Non-overlap: cfg_load pattern=6'b101010, len=6, overlap=0, then the same 10 bits -> z only after bit 6; match_count=1.
- Reconfigure: cfg_load pattern=3'b111, len=3, overlap=1, then feed five 1s -> z after bits 3, 4 and 5. A cfg_load mid-stream discards history, so the next match needs 3 new bits.
- Gaps and invalid config: interleave x_valid=0 cycles into the default stream -> z occurs the cycle after the 6th accepted bit. cfg_len=0 -> cfg_err=1 and no z for any stream.
- Saturation and clear: CNT_W=2, 5 matches -> match_count stays at 3. cnt_clr coinciding with a match -> count 0 and z=1.
- Mid-operation reset: reset_n low after bit 5 of 101010, then bit 6=0 -> no z. Config returns to the defaults.
